// File: rtl/hd44780_text_queue.sv
// Buffers (rs, byte) entries and issues them one at a time to an HD44780 controller,
// inserting a set-DDRAM-address command when a 16-column line fills.
module hd44780_text_queue #(
    parameter int DEPTH_BITS  = 4,
    parameter int GAP_TICKS   = 8,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                  CLK_I,
    input  logic                  RST_I,
    input  logic                  STB_I,
    input  logic                  i_rs,
    input  logic [7:0]            i_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_BITS:0]   o_count,
    output logic                  o_stb,
    output logic                  o_rs,
    output logic [7:0]            o_lcd_data,
    input  logic                  i_busy
);

    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam int AW    = $clog2(ACK_TIMEOUT + 1);
    localparam int GW    = $clog2(GAP_TICKS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STROBE,
        S_WAIT_ACK,
        S_WAIT_IDLE,
        S_GAP
    } state_t;

    logic [8:0]            mem_q [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_BITS:0]   count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic [4:0]            col_q, col_d;
    logic                  line_q, line_d;

    state_t                state_q;
    logic                  stb_q;
    logic                  rs_q;
    logic [7:0]            dat_q;
    logic                  wrap_q;
    logic [AW-1:0]         ack_cnt_q;
    logic [GW-1:0]         gap_cnt_q;

    logic                  push;
    logic                  pop;
    logic                  accept;
    logic [8:0]            head;
    logic                  need_wrap;
    logic                  next_rs;
    logic [7:0]            next_dat;

    assign push   = STB_I & ~full_q;
    assign accept = (state_q == S_WAIT_ACK) & i_busy;
    // Internal wrap commands never came from the FIFO, so they must not pop it.
    assign pop    = accept & ~wrap_q;

    assign head      = mem_q[rd_ptr_q];
    assign need_wrap = head[8] & (col_q == 5'd16);
    assign next_rs   = need_wrap ? 1'b0 : head[8];
    assign next_dat  = need_wrap ? (line_q ? 8'h80 : 8'hC0) : head[7:0];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + DEPTH_BITS'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + DEPTH_BITS'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (DEPTH_BITS+1)'(1);
            2'b01:   count_d = count_q - (DEPTH_BITS+1)'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == (DEPTH_BITS+1)'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_comb begin
        col_d  = col_q;
        line_d = line_q;
        if (accept) begin
            if (wrap_q) begin
                col_d  = 5'd0;
                line_d = ~line_q;
            end else if (rs_q) begin
                if (col_q != 5'd16) begin
                    col_d = col_q + 5'd1;
                end
            end else if (dat_q == 8'h01 || dat_q == 8'h02) begin
                col_d  = 5'd0;
                line_d = 1'b0;
            end else if (dat_q[7]) begin
                line_d = dat_q[6];
                col_d  = {1'b0, dat_q[3:0]};
            end
        end
    end

    always_ff @(posedge CLK_I) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {i_rs, i_data};
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            col_q    <= 5'd0;
            line_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            col_q    <= col_d;
            line_q   <= line_d;
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q   <= S_IDLE;
            stb_q     <= 1'b0;
            rs_q      <= 1'b0;
            dat_q     <= 8'h00;
            wrap_q    <= 1'b0;
            ack_cnt_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!empty_q && !i_busy) begin
                        rs_q    <= next_rs;
                        dat_q   <= next_dat;
                        wrap_q  <= need_wrap;
                        stb_q   <= 1'b1;
                        state_q <= S_STROBE;
                    end
                end
                S_STROBE: begin
                    stb_q     <= 1'b0;
                    ack_cnt_q <= '0;
                    state_q   <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (i_busy) begin
                        state_q <= S_WAIT_IDLE;
                    end else if (ack_cnt_q == AW'(ACK_TIMEOUT - 1)) begin
                        // Controller missed the strobe: re-issue the same item.
                        stb_q   <= 1'b1;
                        state_q <= S_STROBE;
                    end else begin
                        ack_cnt_q <= ack_cnt_q + AW'(1);
                    end
                end
                S_WAIT_IDLE: begin
                    if (!i_busy) begin
                        gap_cnt_q <= GW'(GAP_TICKS);
                        state_q   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (i_busy) begin
                        gap_cnt_q <= GW'(GAP_TICKS);
                    end else if (gap_cnt_q == '0) begin
                        state_q <= S_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - GW'(1);
                    end
                end
                default: begin
                    stb_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_full     = full_q;
    assign o_empty    = empty_q;
    assign o_count    = count_q;
    assign o_stb      = stb_q;
    assign o_rs       = rs_q;
    assign o_lcd_data = dat_q;

endmodule
